// File: rtl/mul_signed_bw_pipe_if.sv
// mul_signed_bw_pipe_if: operand/mask bundle in and result out, each with valid/ready.
interface mul_signed_bw_pipe_if #(
    parameter int IN_W       = 8,
    parameter int OUT_W      = 2*IN_W,
    parameter int N_BIT_RES  = OUT_W-4,
    parameter int N_BIT_APPR = IN_W-1
);
    logic                  i_valid;
    logic                  o_ready;
    logic [IN_W-1:0]       i_a;
    logic [IN_W-1:0]       i_b;
    logic [N_BIT_RES-1:0]  i_res_mask;
    logic [N_BIT_APPR-1:0] i_appr_mask;
    logic                  o_valid;
    logic                  i_ready;
    logic [OUT_W-1:0]      o_res;
    modport slave (
        input  i_valid, i_a, i_b, i_res_mask, i_appr_mask, i_ready,
        output o_ready, o_valid, o_res
    );
    modport master (
        output i_valid, i_a, i_b, i_res_mask, i_appr_mask, i_ready,
        input  o_ready, o_valid, o_res
    );
endinterface

// File: rtl/mul_signed_bw_pipe.sv
// mul_signed_bw_pipe: pipelined signed Baugh-Wooley multiplier with approximation and precision masks.
// MUL_ZERO_GATE_EN: zero operands freeze the datapath registers and only a zero flag travels.
module mul_signed_bw_pipe #(
    parameter int IN_W        = 8,
    parameter int OUT_W       = 2*IN_W,
    parameter int N_BIT_RES   = OUT_W-4,
    parameter int N_BIT_APPR  = IN_W-1,
    parameter int PIPE_STAGES = 2
) (
    input logic                 i_clk,
    input logic                 i_rst,
    input logic                 i_flush,
    mul_signed_bw_pipe_if.slave bus
);
`ifdef MUL_ZERO_GATE_EN
    localparam bit ZG = 1'b1;
`else
    localparam bit ZG = 1'b0;
`endif
    // Baugh-Wooley correction constants at columns IN_W and OUT_W-1
    localparam logic [OUT_W-1:0] BW_ONES = (OUT_W'(1) << IN_W) | (OUT_W'(1) << (OUT_W-1));

    typedef struct packed {
        logic [OUT_W-1:0]     lo;
        logic [OUT_W-1:0]     hi;
        logic                 sgn;
        logic [N_BIT_RES-1:0] rm;
    } mid_t;

    logic                   rdy_q;
    logic                   ready;
    logic                   advance;
    logic                   accept;
    logic                   zero_in;
    logic [PIPE_STAGES-1:0] vld_q;
    logic [PIPE_STAGES-1:0] vld_d;
    logic [OUT_W-1:0]       appr_ext;
    logic [OUT_W-1:0]       row;
    logic                   pp;
    mid_t                   mid_d;
    mid_t                   fin_src;
    logic                   fin_zero;
    logic [OUT_W-1:0]       papp;
    logic [OUT_W-1:0]       res_d;
    logic [OUT_W-1:0]       o_res_q;

    assign advance     = ~vld_q[PIPE_STAGES-1] | bus.i_ready;
    assign ready       = advance & rdy_q;
    assign accept      = bus.i_valid & ready;
    assign zero_in     = ~|bus.i_a | ~|bus.i_b;
    assign appr_ext    = {{(OUT_W-N_BIT_APPR){1'b1}}, bus.i_appr_mask};
    assign bus.o_ready = ready;
    assign bus.o_valid = vld_q[PIPE_STAGES-1];
    assign bus.o_res   = o_res_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) rdy_q <= 1'b0;
        else rdy_q <= 1'b1;
    end

    // Partial-product rows split into two halves so the first register sits mid-tree
    always_comb begin
        mid_d.lo = BW_ONES;
        mid_d.hi = '0;
        row = '0;
        pp = 1'b0;
        for (int i = 0; i < IN_W; i++) begin
            row = '0;
            for (int j = 0; j < IN_W; j++) begin
                pp = bus.i_a[j] & bus.i_b[i];
                if ((i == IN_W-1) != (j == IN_W-1)) pp = ~pp;
                if (!appr_ext[i+j]) pp = 1'b0;
                row[i+j] = pp;
            end
            if (i < IN_W/2) mid_d.lo = mid_d.lo + row;
            else mid_d.hi = mid_d.hi + row;
        end
        mid_d.sgn = (bus.i_a[IN_W-1] ^ bus.i_b[IN_W-1]) & ~zero_in;
        mid_d.rm  = bus.i_res_mask;
    end

    always_comb begin
        vld_d = vld_q;
        if (advance) begin
            vld_d[0] = accept;
            for (int s = 1; s < PIPE_STAGES; s++) vld_d[s] = vld_q[s-1];
        end
        if (i_flush) vld_d = '0;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) vld_q <= '0;
        else vld_q <= vld_d;
    end

    generate
        if (PIPE_STAGES > 1) begin : g_mid
            mid_t                   m_q [PIPE_STAGES-1];
            logic [PIPE_STAGES-2:0] z_q;
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    for (int s = 0; s < PIPE_STAGES-1; s++) m_q[s] <= '0;
                    z_q <= '0;
                end else if (advance) begin
                    if (vld_d[0] && !(ZG && zero_in)) m_q[0] <= mid_d;
                    z_q[0] <= zero_in;
                    for (int s = 1; s < PIPE_STAGES-1; s++) begin
                        if (vld_d[s] && !(ZG && z_q[s-1])) m_q[s] <= m_q[s-1];
                        z_q[s] <= z_q[s-1];
                    end
                end
            end
            assign fin_src  = m_q[PIPE_STAGES-2];
            assign fin_zero = z_q[PIPE_STAGES-2];
        end else begin : g_direct
            assign fin_src  = mid_d;
            assign fin_zero = zero_in;
        end
    endgenerate

    always_comb begin
        papp  = fin_src.lo + fin_src.hi;
        res_d = papp;
        for (int k = 0; k < N_BIT_RES; k++) res_d[k+4] = fin_src.rm[k] ? papp[k+4] : fin_src.sgn;
    end

    // Only a real bundle reaching the output may touch o_res
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) o_res_q <= '0;
        else if (advance && vld_d[PIPE_STAGES-1]) o_res_q <= (ZG && fin_zero) ? '0 : res_d;
    end
endmodule

// File: tb/tb_mul_signed_bw_pipe.sv
// tb_mul_signed_bw_pipe: directed vectors and handshake sequences on PIPE_STAGES = 1, 2 and 4.
module tb_mul_signed_bw_pipe;
    logic              clk = 1'b0, rst = 1'b1, flush = 1'b0;
    logic              vval = 1'b0, vrdy = 1'b1;
    logic signed [7:0] va = '0, vb = '0;
    logic [11:0]       vrm = '1;
    logic [6:0]        vam = '1;
    int                n_run = 0, n_fail = 0;

    always #5 clk = ~clk;

    mul_signed_bw_pipe_if #(.IN_W(8)) bus1 (), bus2 (), bus4 ();
    assign {bus1.i_valid, bus1.i_a, bus1.i_b, bus1.i_res_mask, bus1.i_appr_mask, bus1.i_ready} = {vval, va, vb, vrm, vam, vrdy};
    assign {bus2.i_valid, bus2.i_a, bus2.i_b, bus2.i_res_mask, bus2.i_appr_mask, bus2.i_ready} = {vval, va, vb, vrm, vam, vrdy};
    assign {bus4.i_valid, bus4.i_a, bus4.i_b, bus4.i_res_mask, bus4.i_appr_mask, bus4.i_ready} = {vval, va, vb, vrm, vam, vrdy};

    mul_signed_bw_pipe #(.IN_W(8), .PIPE_STAGES(1)) dut1 (.i_clk(clk), .i_rst(rst), .i_flush(flush), .bus(bus1));
    mul_signed_bw_pipe #(.IN_W(8), .PIPE_STAGES(2)) dut2 (.i_clk(clk), .i_rst(rst), .i_flush(flush), .bus(bus2));
    mul_signed_bw_pipe #(.IN_W(8), .PIPE_STAGES(4)) dut4 (.i_clk(clk), .i_rst(rst), .i_flush(flush), .bus(bus4));

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [11:0] rm;
        logic [6:0]  am;
        logic [15:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic send_one(input logic [7:0] a, input logic [7:0] b, input logic [11:0] rm, input logic [6:0] am,
                            output int l1, output int l2, output int l4,
                            output logic [15:0] r1, output logic [15:0] r2, output logic [15:0] r4);
        @(negedge clk);
        va = a; vb = b; vrm = rm; vam = am; vval = 1'b1;
        @(negedge clk);
        vval = 1'b0;
        l1 = 0; l2 = 0; l4 = 0; r1 = '0; r2 = '0; r4 = '0;
        for (int k = 1; k <= 6; k++) begin
            if (bus1.o_valid && l1 == 0) begin l1 = k; r1 = bus1.o_res; end
            if (bus2.o_valid && l2 == 0) begin l2 = k; r2 = bus2.o_res; end
            if (bus4.o_valid && l4 == 0) begin l4 = k; r4 = bus4.o_res; end
            if (k < 6) @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        vt [13];
        logic [7:0]  sa [6];
        logic [7:0]  sb [6];
        logic [15:0] se [6];
        int          l1, l2, l4, sent, got, nv;
        logic [15:0] r1, r2, r4, held;
        logic        stalled;
        vt[0]  = '{8'h80, 8'h80, 12'hFFF, 7'h7F, 16'h4000};
        vt[1]  = '{8'h80, 8'h7F, 12'hFFF, 7'h7F, 16'hC080};
        vt[2]  = '{8'hFF, 8'hFF, 12'hFFF, 7'h7F, 16'h0001};
        vt[3]  = '{8'h07, 8'h05, 12'hFFF, 7'h7F, 16'h0023};
        vt[4]  = '{8'h07, 8'h05, 12'hFFF, 7'h7E, 16'h0022};
        vt[5]  = '{8'h07, 8'h05, 12'hFFF, 7'h7A, 16'h001A};
        vt[6]  = '{8'h64, 8'h03, 12'h00F, 7'h7F, 16'h002C};
        vt[7]  = '{8'h9C, 8'h03, 12'h00F, 7'h7F, 16'hFFD4};
        vt[8]  = '{8'h00, 8'hFB, 12'h00F, 7'h7F, 16'h0000};
        vt[9]  = '{8'h7F, 8'h7F, 12'hFFF, 7'h7F, 16'h3F01};
        vt[10] = '{8'h64, 8'h64, 12'h0F0, 7'h7F, 16'h0700};
        vt[11] = '{8'hFF, 8'hFF, 12'hFFF, 7'h7E, 16'h0000};
        vt[12] = '{8'hFB, 8'h00, 12'h000, 7'h7F, 16'h0000};
        sa = '{8'h03, 8'hF9, 8'h0C, 8'h80, 8'h7F, 8'hFF};
        sb = '{8'h05, 8'h09, 8'hF5, 8'h02, 8'hFD, 8'h80};
        se = '{16'h000F, 16'hFFC1, 16'hFF7C, 16'hFF00, 16'hFE83, 16'h0080};

        @(negedge clk);
        @(negedge clk);
        check("reset o_valid p2", bus2.o_valid, 0);
        check("reset o_res p2", bus2.o_res, 0);
        check("reset o_valid p4", bus4.o_valid, 0);
        check("reset o_res p1", bus1.o_res, 0);
        rst = 1'b0;
        @(negedge clk);
        check("o_ready after reset", bus2.o_ready, 1);

        for (int i = 0; i < 13; i++) begin
            send_one(vt[i].a, vt[i].b, vt[i].rm, vt[i].am, l1, l2, l4, r1, r2, r4);
            check($sformatf("vec%0d res p1", i), r1, vt[i].exp);
            check($sformatf("vec%0d res p2", i), r2, vt[i].exp);
            check($sformatf("vec%0d res p4", i), r4, vt[i].exp);
            check($sformatf("vec%0d lat p1", i), l1, 1);
            check($sformatf("vec%0d lat p2", i), l2, 2);
            check($sformatf("vec%0d lat p4", i), l4, 4);
        end
        check("o_res holds while idle", bus2.o_res, 16'h0000);

        vrm = '1; vam = '1; sent = 0; got = 0; stalled = 1'b0; held = '0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            @(negedge clk);
            vrdy = !(cyc >= 4 && cyc <= 6);
            vval = (sent < 6);
            if (sent < 6) begin va = sa[sent]; vb = sb[sent]; end
            #1;
            if (stalled) begin
                check("stall keeps o_valid", bus2.o_valid, 1);
                check("stall keeps o_res", bus2.o_res, held);
            end
            stalled = bus2.o_valid && !vrdy;
            if (stalled) begin
                check("stall o_ready", bus2.o_ready, 0);
                held = bus2.o_res;
            end
            if (vval && bus2.o_ready) sent++;
            if (bus2.o_valid && vrdy) begin
                check($sformatf("stream out %0d", got), bus2.o_res, se[got]);
                got++;
            end
        end
        vval = 1'b0; vrdy = 1'b1;
        check("stream sent", sent, 6);
        check("stream received", got, 6);
        repeat (3) @(negedge clk);
        check("stream no extra", bus2.o_valid, 0);

        @(negedge clk);
        va = 8'd10; vb = 8'd11; vval = 1'b1;
        @(negedge clk);
        va = 8'd12; vb = 8'd13;
        @(negedge clk);
        va = 8'd14; vb = 8'd15; flush = 1'b1;
        #1;
        check("flush o_ready", bus2.o_ready, 1);
        @(negedge clk);
        flush = 1'b0; vval = 1'b0;
        nv = 0;
        for (int k = 0; k < 6; k++) begin
            if (bus2.o_valid || bus4.o_valid) nv++;
            @(negedge clk);
        end
        check("flush no o_valid", nv, 0);
        check("flush o_res held", bus2.o_res, 16'd110);
        send_one(8'd3, 8'd4, 12'hFFF, 7'h7F, l1, l2, l4, r1, r2, r4);
        check("post flush res", r2, 16'd12);
        check("post flush lat", l2, 2);

        @(negedge clk);
        va = 8'd5; vb = 8'd6; vval = 1'b1;
        @(negedge clk);
        va = 8'd7; vb = 8'd8;
        @(negedge clk);
        vval = 1'b0;
        check("pre-reset o_valid p2", bus2.o_valid, 1);
        #2 rst = 1'b1;
        #1;
        check("async reset o_valid p2", bus2.o_valid, 0);
        check("async reset o_res p2", bus2.o_res, 0);
        check("async reset o_res p1", bus1.o_res, 0);
        check("async reset o_valid p4", bus4.o_valid, 0);
        #1 rst = 1'b0;
        @(negedge clk);
        check("ready after async reset", bus2.o_ready, 1);
        nv = 0;
        for (int k = 0; k < 5; k++) begin
            if (bus1.o_valid || bus2.o_valid || bus4.o_valid) nv++;
            @(negedge clk);
        end
        check("no output after reset", nv, 0);
        send_one(8'h80, 8'h80, 12'hFFF, 7'h7F, l1, l2, l4, r1, r2, r4);
        check("rerun case1 p1", r1, 16'h4000);
        check("rerun case1 p4", r4, 16'h4000);
        check("rerun case1 lat p4", l4, 4);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
